// File: rtl/la_imem_loader.sv
// Logic-analyser driven loader: the management CPU streams 16-bit halves over
// a toggle-strobed command word and this block assembles and writes them to core IMEM.
module la_imem_loader #(
  parameter int ADDR_W = 8
) (
  input  logic              wb_clk_i,
  input  logic              wb_rst_i,
  input  logic [31:0]       la1_data_in,
  input  logic [31:0]       la1_oenb,
  output logic [31:0]       la1_data_out,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [31:0]       imem_wdata,
  output logic              core_rst
);

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_LOAD_LO = 3'd1,
    ST_LOAD_HI = 3'd2,
    ST_WRITE   = 3'd3,
    ST_RUN     = 3'd4
  } state_e;

  typedef enum logic [1:0] {
    OP_NOP   = 2'b00,
    OP_START = 2'b01,
    OP_DATA  = 2'b10,
    OP_RUN   = 2'b11
  } op_e;

  state_e            r_state;
  logic              r_tog;
  logic              r_we;
  logic              r_core_rst;
  logic              r_err;
  logic [ADDR_W-1:0] r_addr;
  logic [31:0]       r_wdata;
  logic [ADDR_W:0]   r_count;
  logic [15:0]       r_csum;

  logic              w_acc;
  op_e               w_op;
  logic [15:0]       w_payload;
  logic [8:0]        w_cnt9;
  logic              w_full;
  logic              w_unused;

  assign w_acc     = !la1_oenb[31] && (la1_data_in[31] != r_tog);
  assign w_op      = op_e'(la1_data_in[30:29]);
  assign w_payload = la1_data_in[15:0];
  // count never exceeds 2^ADDR_W, so its MSB alone flags a full memory
  assign w_full    = r_count[ADDR_W];
  assign w_unused  = ^{la1_oenb[30:0], la1_data_in[28:16]};

  generate
    if (ADDR_W + 1 >= 9) begin : g_cnt_trunc
      assign w_cnt9 = r_count[8:0];
    end else begin : g_cnt_ext
      assign w_cnt9 = {{(8 - ADDR_W){1'b0}}, r_count};
    end
  endgenerate

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      r_state    <= ST_IDLE;
      r_tog      <= 1'b0;
      r_we       <= 1'b0;
      r_core_rst <= 1'b1;
      r_err      <= 1'b0;
      r_addr     <= '0;
      r_wdata    <= '0;
      r_count    <= '0;
      r_csum     <= '0;
    end else begin
      if (!la1_oenb[31]) r_tog <= la1_data_in[31];
      r_we <= 1'b0;
      if (r_state == ST_WRITE) begin
        // the write itself always completes; a command landing here is only flagged
        if (!w_full) begin
          r_addr  <= r_addr + ADDR_W'(1);
          r_count <= r_count + (ADDR_W + 1)'(1);
          r_csum  <= r_csum + r_wdata[15:0] + r_wdata[31:16];
        end else begin
          r_err <= 1'b1;
        end
        if (w_acc) r_err <= 1'b1;
        r_state <= ST_LOAD_LO;
      end else if (w_acc) begin
        case (w_op)
          OP_START: begin
            r_addr     <= w_payload[ADDR_W-1:0];
            r_count    <= '0;
            r_csum     <= '0;
            r_err      <= 1'b0;
            r_core_rst <= 1'b1;
            r_state    <= ST_LOAD_LO;
          end
          OP_DATA: begin
            if (r_state == ST_LOAD_LO) begin
              r_wdata[15:0] <= w_payload;
              r_state       <= ST_LOAD_HI;
            end else if (r_state == ST_LOAD_HI) begin
              r_wdata[31:16] <= w_payload;
              r_we           <= !w_full && r_core_rst;
              r_state        <= ST_WRITE;
            end else begin
              r_err <= 1'b1;
            end
          end
          OP_RUN: begin
            if (r_state == ST_RUN) begin
              r_err <= 1'b1;
            end else begin
              if (r_state == ST_LOAD_HI) r_err <= 1'b1;
              r_core_rst <= 1'b0;
              r_state    <= ST_RUN;
            end
          end
          default: ;
        endcase
      end
    end
  end

  assign imem_we      = r_we;
  assign imem_addr    = r_addr;
  assign imem_wdata   = r_wdata;
  assign core_rst     = r_core_rst;
  assign la1_data_out = {r_core_rst, r_state, r_err, 2'b00, w_cnt9, r_csum};

endmodule

// File: tb/tb_la_imem_loader.sv
// Scoreboarded bench for la_imem_loader: expected IMEM writes are queued by the
// stimulus and popped by an independent write monitor; status words are checked inline.
module tb_la_imem_loader;

  logic        clk;
  logic        rst;
  logic [31:0] la_in;
  logic [31:0] la_oenb;
  logic [31:0] la_out;
  logic        we;
  logic [7:0]  addr;
  logic [31:0] wdata;
  logic        crst;

  int checks = 0;
  int errors = 0;
  logic tb_tog = 1'b0;
  logic [39:0] sb_q[$];

  la_imem_loader #(.ADDR_W(8)) dut (
    .wb_clk_i    (clk),
    .wb_rst_i    (rst),
    .la1_data_in (la_in),
    .la1_oenb    (la_oenb),
    .la1_data_out(la_out),
    .imem_we     (we),
    .imem_addr   (addr),
    .imem_wdata  (wdata),
    .core_rst    (crst)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Write monitor: every imem_we pulse must match the head of the scoreboard.
  always @(negedge clk) begin
    if (we === 1'b1) begin
      logic [39:0] e;
      checks++;
      if (sb_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_write: got addr 0x%02h data 0x%08h expected no write", addr, wdata);
      end else begin
        e = sb_q.pop_front();
        if ({addr, wdata} !== e || crst !== 1'b1) begin
          errors++;
          $display("FAIL write: got addr 0x%02h data 0x%08h crst %0b expected addr 0x%02h data 0x%08h crst 1",
                   addr, wdata, crst, e[39:32], e[31:0]);
        end
      end
    end
  end

  task automatic send(input logic [1:0] op, input logic [15:0] payload);
    tb_tog = ~tb_tog;
    la_in  = {tb_tog, op, 13'd0, payload};
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst    = 1'b1;
    tb_tog = 1'b0;
    la_in  = '0;
    idle(2);
    rst = 1'b0;
    idle(1);
  endtask

  task automatic word(input logic [7:0] a, input logic [15:0] lo, input logic [15:0] hi, input bit expect_wr);
    if (expect_wr) sb_q.push_back({a, hi, lo});
    send(2'b10, lo);
    send(2'b10, hi);
    idle(1);
  endtask

  initial begin
    rst     = 1'b1;
    la_in   = '0;
    la_oenb = '0;
    idle(2);
    check("reset_status", la_out, 32'h8000_0000);
    check("reset_we", {31'd0, we}, 32'd0);
    check("reset_addr_wdata", {24'd0, addr} | wdata, 32'd0);
    rst = 1'b0;
    idle(2);
    check("post_release_status", la_out, 32'h8000_0000);

    // Single word at 0x10
    send(2'b01, 16'h0010);
    word(8'h10, 16'h5678, 16'h1234, 1'b1);
    check("word1_status", la_out, 32'h9001_68AC);
    check("word1_addr", {24'd0, addr}, 32'h11);

    // Address wrap from 0xFF to 0x00
    send(2'b01, 16'h00FF);
    word(8'hFF, 16'h0001, 16'h0002, 1'b1);
    word(8'h00, 16'h0003, 16'h0004, 1'b1);
    check("wrap_status", la_out, 32'h9002_000A);
    check("wrap_addr", {24'd0, addr}, 32'h01);

    // Fill all 256 words, then overflow
    send(2'b01, 16'h0000);
    for (int i = 0; i < 256; i++)
      word(8'(i), 16'(i), 16'(16'h0100 + i), 1'b1);
    check("full_status", la_out, 32'h9100_FF00);
    word(8'h00, 16'hDEAD, 16'hBEEF, 1'b0);
    check("overflow_status", la_out, 32'h9900_FF00);
    check("overflow_addr", {24'd0, addr}, 32'h00);

    // RUN with only the low half loaded
    send(2'b01, 16'h0020);
    send(2'b10, 16'hAAAA);
    send(2'b11, 16'h0000);
    idle(2);
    check("run_lohalf_status", la_out, 32'h4800_0000);
    check("run_lohalf_crst", {31'd0, crst}, 32'd0);
    send(2'b10, 16'h1111);
    check("data_in_run_status", la_out, 32'h4800_0000);

    // DATA in IDLE, then strobe while the CPU does not own it
    do_reset();
    send(2'b10, 16'h4321);
    check("data_idle_status", la_out, 32'h8800_0000);
    la_oenb[31] = 1'b1;
    send(2'b01, 16'h0040);
    idle(2);
    check("oenb_blocked_status", la_out, 32'h8800_0000);
    tb_tog = ~tb_tog;
    la_in[31] = tb_tog;
    @(negedge clk);
    la_oenb[31] = 1'b0;
    idle(2);
    check("oenb_restore_status", la_out, 32'h8800_0000);

    // Reset asserted while the write strobe is high
    send(2'b01, 16'h0030);
    send(2'b10, 16'h0001);
    tb_tog = ~tb_tog;
    la_in  = {tb_tog, 2'b10, 13'd0, 16'h0002};
    @(posedge clk);
    #1;
    check("we_before_reset", {31'd0, we}, 32'd1);
    rst    = 1'b1;
    tb_tog = 1'b0;
    la_in  = '0;
    #1;
    check("we_async_drop", {31'd0, we}, 32'd0);
    check("reset_mid_write_status", la_out, 32'h8000_0000);
    idle(2);
    rst = 1'b0;
    idle(2);
    check("after_reset_status", la_out, 32'h8000_0000);

    check("scoreboard_drained", sb_q.size(), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/la_imem_loader.md
LA_IMEM_LOADER -- requirements
Module: la_imem_loader

Interface
REQ-001 SHALL have parameter ADDR_W, default 8, the instruction-memory word-address width (depth 2^ADDR_W words).
REQ-002 SHALL have port wb_clk_i, input, 1, the single system clock; all state changes on its rising edge.
REQ-003 SHALL have port wb_rst_i, input, 1, reset; asynchronous assertion, active-high.
REQ-004 SHALL have port la1_data_in, input, 32, the command word from the management CPU.
- [31] toggle strobe; [30:29] opcode; [15:0] payload.
REQ-005 SHALL have port la1_oenb, input, 32; only bit [31] is used; 0 means the CPU drives the strobe.
REQ-006 SHALL have port la1_data_out, output, 32, the status word (REQ-020).
REQ-007 SHALL have port imem_we, output, 1, the one-cycle write strobe to the core instruction memory.
REQ-008 SHALL have port imem_addr, output, ADDR_W, the write word address.
REQ-009 SHALL have port imem_wdata, output, 32, the write data.
REQ-010 SHALL have port core_rst, output, 1, the active-high reset held on the downstream RV32I core.

Function
REQ-011 SHALL register strobe tog_q <= la1_data_in[31] every cycle in which la1_oenb[31]==0; tog_q holds otherwise.
REQ-012 SHALL accept exactly one command in a cycle where la1_oenb[31]==0 and la1_data_in[31]!=tog_q; no other cycle accepts a command.
REQ-013 SHALL decode opcodes 00 NOP (no effect), 01 START, 10 DATA, 11 RUN.
REQ-014 SHALL implement states IDLE=0, LOAD_LO=1, LOAD_HI=2, WRITE=3, RUN=4 (3-bit encoding).
REQ-015 SHALL, on START in any state except WRITE:
- imem_addr <= payload[ADDR_W-1:0]; count <= 0; checksum <= 0; error <= 0; core_rst <= 1; next state LOAD_LO.
REQ-016 SHALL, on DATA:
- in LOAD_LO: imem_wdata[15:0] <= payload; next state LOAD_HI.
- in LOAD_HI: imem_wdata[31:16] <= payload; next state WRITE.
REQ-017 SHALL, in WRITE (exactly one cycle), assert imem_we=1 with the current imem_addr/imem_wdata, then on the next edge:
- imem_addr+1 (wrap 2^ADDR_W-1 -> 0); count+1; checksum += wdata[15:0] + wdata[31:16] modulo 2^16; next state LOAD_LO.
REQ-018 SHALL treat count as ADDR_W+1 bits. When count == 2^ADDR_W, WRITE suppresses imem_we, sets error, and leaves count, imem_addr and checksum unchanged.
REQ-019 SHALL handle RUN as follows:
- in IDLE or LOAD_LO: core_rst <= 0; next state RUN.
- in LOAD_HI: discard the low half; error <= 1; core_rst <= 0; next state RUN.
REQ-020 SHALL drive la1_data_out as a combinational view of registers:
- [31] core_rst; [30:28] state; [27] error; [26:25] 0; [24:16] count (zero-extended/truncated to 9 bits); [15:0] checksum.
REQ-021 SHALL set sticky error for each of the following, with no other state change:
- a command accepted while in WRITE;
- DATA accepted in IDLE or RUN;
- START/DATA interaction violating REQ-015/016.
REQ-022 SHALL, in RUN, accept only START (re-enters load, re-asserts core_rst) and NOP; DATA and RUN are errors with no state change.
REQ-023 SHALL never assert imem_we outside WRITE, and never while core_rst==0.

Reset
REQ-024 SHALL, while wb_rst_i==1, force:
- state IDLE; core_rst=1; imem_we=0; imem_addr=0; imem_wdata=0; count=0; checksum=0; error=0; tog_q=0.
REQ-025 SHALL, on reset asserted mid-WRITE, drop imem_we in the same cycle (asynchronously); the pending word is lost.
REQ-026 SHALL leave the first edge after reset release with state IDLE; a strobe level of 1 at release is accepted as a command.

Verification
REQ-027 Bench SHALL check: START payload 0x0010; DATA 0x5678; DATA 0x1234 -> one imem_we pulse, addr 0x10, wdata 0x12345678; then count=1, checksum=0x68AC, addr 0x11.
REQ-028 Bench SHALL check: START 0x00FF, two full words -> writes at 0xFF then 0x00; count=2.
REQ-029 Bench SHALL check: 256 words after START 0, then one more word -> 257th write suppressed; la1_data_out[27]=1; count=256.
REQ-030 Bench SHALL check: START, DATA 0xAAAA, RUN -> no write; core_rst=0; state 4; error=1.
REQ-031 Bench SHALL check: DATA in IDLE -> error=1, state 0; strobe toggled with la1_oenb[31]=1 -> no command accepted.
REQ-032 Bench SHALL check: wb_rst_i pulsed during WRITE -> imem_we=0 immediately; la1_data_out=0x80000000.
